// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the sample-tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    // Clocks per oversample tick, truncated toward zero.
    function automatic int calc_div(input int clock_freq, input int baud_rate, input int oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/UART_parameters.sv
// Board-level UART timing defaults shared by the receiver and transmitter.
// Override by defining these macros before this file is read.
`ifndef UART_PARAMETERS_SV
`define UART_PARAMETERS_SV

`ifndef CLOCK_FREQ_p
`define CLOCK_FREQ_p 100_000_000
`endif

`ifndef BAUD_RATE_p
`define BAUD_RATE_p 115200
`endif

`endif

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held in phase zero while clear is high.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_baud_tick: DIV must be at least 1");
    end

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Combinational so the first tick lands exactly DIV clocks after clear drops.
    assign tick = !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with majority-vote bit decisions, optional parity,
// and a valid/ready output holding register with overrun detection.
`include "UART_parameters.sv"

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = `CLOCK_FREQ_p,
    parameter int BAUD_RATE  = `BAUD_RATE_p,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_VOTE0  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_VOTE1  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DECIDE = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx: CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
        $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_check
        $error("uart_rx: DATA_BITS must be in 5..9");
    end

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 prev_q;
    rx_state_e            state_q;
    logic [SW-1:0]        samp_q;
    logic [BW-1:0]        bitcnt_q;
    logic [1:0]           vote_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    logic tick;
    logic tick_clear;
    logic start_edge;
    logic maj_bit;
    logic par_exp;
    logic accept;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick_clear = (state_q == ST_IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    assign start_edge = prev_q & ~sync2_q;
    // Third vote is the live sample at the decision tick.
    assign maj_bit    = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) | (vote_q[1] & sync2_q);
    assign par_exp    = (^shift_q) ^ (PARITY_ODD != 0);
    assign accept     = rx_valid_q & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            samp_q       <= '0;
            bitcnt_q     <= '0;
            vote_q       <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            if (accept) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    samp_q    <= '0;
                    bitcnt_q  <= '0;
                    par_bad_q <= 1'b0;
                    if (start_edge) begin
                        state_q <= ST_START;
                    end
                end

                ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                    if (tick) begin
                        samp_q <= (samp_q == S_LAST) ? '0 : samp_q + SW'(1);
                        if (samp_q == S_VOTE0) begin
                            vote_q[0] <= sync2_q;
                        end
                        if (samp_q == S_VOTE1) begin
                            vote_q[1] <= sync2_q;
                        end

                        if (samp_q == S_DECIDE) begin
                            case (state_q)
                                ST_START: begin
                                    if (maj_bit) begin
                                        state_q <= ST_IDLE;
                                    end
                                end
                                ST_DATA: begin
                                    shift_q <= {maj_bit, shift_q[DATA_BITS-1:1]};
                                end
                                ST_PARITY: begin
                                    par_bad_q <= (maj_bit != par_exp);
                                end
                                ST_STOP: begin
                                    // Stop is resolved mid-bit so the next start edge is never missed.
                                    if (!maj_bit) begin
                                        frame_err_q <= 1'b1;
                                        state_q     <= ST_WAIT_IDLE;
                                    end else begin
                                        state_q <= ST_IDLE;
                                        if (par_bad_q) begin
                                            parity_err_q <= 1'b1;
                                        end else if (rx_valid_q && !rx_ready) begin
                                            overrun_q <= 1'b1;
                                        end else begin
                                            rx_data_q  <= shift_q;
                                            rx_valid_q <= 1'b1;
                                        end
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end

                        if (samp_q == S_LAST) begin
                            case (state_q)
                                ST_START: begin
                                    state_q <= ST_DATA;
                                end
                                ST_DATA: begin
                                    if (bitcnt_q == B_LAST) begin
                                        bitcnt_q <= '0;
                                        state_q  <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                                    end else begin
                                        bitcnt_q <= bitcnt_q + BW'(1);
                                    end
                                end
                                ST_PARITY: begin
                                    state_q <= ST_STOP;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    if (sync2_q) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: three 8N1 receivers and one even-parity receiver driven by directed frames.
module tb_uart_rx;

    localparam int BIT_CLKS  = 864;
    // Negedges from start-bit fall to the cycle whose closing edge makes the stop decision:
    // 2 synchronizer edges + 154 ticks of 54 clocks.
    localparam int STOP_EDGE = 8318;

    typedef enum logic [1:0] {EV_DATA, EV_FERR, EV_PERR, EV_OVR} ev_kind_e;
    typedef struct packed {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    ev_t sb_q [4][$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rx_v;
    logic [3:0] ready_v;
    logic [7:0] rx_data_w [4];
    logic [3:0] valid_w;
    logic [3:0] ferr_w;
    logic [3:0] perr_w;
    logic [3:0] ovr_w;

    int checks;
    int errors;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_rx #(
            .CLOCK_FREQ (100_000_000),
            .BAUD_RATE  (115200),
            .OVERSAMPLE (16),
            .DATA_BITS  (8),
            .PARITY_EN  ((g == 3) ? 1 : 0),
            .PARITY_ODD (0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .rx         (rx_v[g]),
            .rx_data    (rx_data_w[g]),
            .rx_valid   (valid_w[g]),
            .rx_ready   (ready_v[g]),
            .frame_err  (ferr_w[g]),
            .parity_err (perr_w[g]),
            .overrun    (ovr_w[g])
        );
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void expect_ev(input int ch, input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb_q[ch].push_back(e);
    endfunction

    function automatic void got_ev(input int ch, input ev_kind_e k, input logic [7:0] d);
        checks++;
        if (sb_q[ch].size() == 0) begin
            errors++;
            $display("FAIL ch%0d_event actual=%s data=%02h required=none", ch, k.name(), d);
        end else begin
            ev_t e;
            e = sb_q[ch].pop_front();
            if ((e.kind != k) || ((k == EV_DATA) && (e.data !== d))) begin
                errors++;
                $display("FAIL ch%0d_event actual=%s data=%02h required=%s data=%02h",
                         ch, k.name(), d, e.kind.name(), e.data);
            end
        end
    endfunction

    task automatic monitor();
        logic [3:0] pv;
        logic [7:0] pd [4];
        pv = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pv = '0;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (ferr_w[c]) got_ev(c, EV_FERR, 8'h00);
                    if (perr_w[c]) got_ev(c, EV_PERR, 8'h00);
                    if (ovr_w[c])  got_ev(c, EV_OVR, 8'h00);
                    if (valid_w[c] && (!pv[c] || ready_v[c])) begin
                        got_ev(c, EV_DATA, rx_data_w[c]);
                    end else if (valid_w[c] && (rx_data_w[c] !== pd[c])) begin
                        errors++;
                        $display("FAIL ch%0d_data_hold actual=%02h required=%02h", c, rx_data_w[c], pd[c]);
                    end
                    pv[c] = valid_w[c];
                    pd[c] = rx_data_w[c];
                end
            end
        end
    endtask

    task automatic send_frame(input int ch, input logic [7:0] data, input bit par_en,
                              input bit par_bit, input bit stop_bit, input int stop_bits);
        @(negedge clk);
        rx_v[ch] = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_v[ch] = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (par_en) begin
            rx_v[ch] = par_bit;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_v[ch] = stop_bit;
        repeat (BIT_CLKS * stop_bits) @(negedge clk);
        rx_v[ch] = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        rx_v    = '1;
        ready_v = '0;
        fork
            monitor();
        join_none

        repeat (5) @(negedge clk);
        check("reset_valid", valid_w, 4'h0);
        check("reset_frame_err", ferr_w, 4'h0);
        check("reset_parity_err", perr_w, 4'h0);
        check("reset_overrun", ovr_w, 4'h0);
        for (int c = 0; c < 4; c++) check($sformatf("reset_data_ch%0d", c), rx_data_w[c], 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        fork
            begin
                expect_ev(0, EV_DATA, 8'hA5);
                send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
                repeat (100) @(negedge clk);
                check("a5_valid_held", valid_w[0], 1);
                check("a5_data", rx_data_w[0], 8'hA5);
                ready_v[0] = 1'b1;
                @(negedge clk);
                ready_v[0] = 1'b0;
                check("a5_valid_cleared", valid_w[0], 0);
                rx_v[0] = 1'b0;
                repeat (BIT_CLKS / 4) @(negedge clk);
                rx_v[0] = 1'b1;
                repeat (3 * BIT_CLKS) @(negedge clk);
                check("glitch_no_valid", valid_w[0], 0);
                expect_ev(0, EV_DATA, 8'h0F);
                send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1, 1);
                check("after_glitch_data", rx_data_w[0], 8'h0F);
            end
            begin
                expect_ev(1, EV_FERR, 8'h00);
                send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b0, 2);
                check("ferr_no_valid", valid_w[1], 0);
                expect_ev(1, EV_DATA, 8'h11);
                send_frame(1, 8'h11, 1'b0, 1'b0, 1'b1, 1);
                check("after_ferr_data", rx_data_w[1], 8'h11);
            end
            begin
                expect_ev(2, EV_DATA, 8'h12);
                send_frame(2, 8'h12, 1'b0, 1'b0, 1'b1, 1);
                expect_ev(2, EV_OVR, 8'h00);
                send_frame(2, 8'h34, 1'b0, 1'b0, 1'b1, 1);
                check("overrun_keeps_data", rx_data_w[2], 8'h12);
                check("overrun_valid", valid_w[2], 1);
                expect_ev(2, EV_DATA, 8'h34);
                fork
                    send_frame(2, 8'h34, 1'b0, 1'b0, 1'b1, 1);
                    begin
                        @(negedge clk);
                        repeat (STOP_EDGE) @(negedge clk);
                        ready_v[2] = 1'b1;
                        @(negedge clk);
                        ready_v[2] = 1'b0;
                    end
                join
                check("same_cycle_hs_data", rx_data_w[2], 8'h34);
                check("same_cycle_hs_valid", valid_w[2], 1);
            end
            begin
                expect_ev(3, EV_PERR, 8'h00);
                send_frame(3, 8'h01, 1'b1, 1'b0, 1'b1, 1);
                check("perr_no_valid", valid_w[3], 0);
                expect_ev(3, EV_DATA, 8'h01);
                send_frame(3, 8'h01, 1'b1, 1'b1, 1'b1, 1);
                check("parity_ok_data", rx_data_w[3], 8'h01);
            end
        join

        for (int c = 0; c < 4; c++) check($sformatf("sb_drained_ch%0d", c), sb_q[c].size(), 0);

        @(negedge clk);
        rx_v[0] = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid_w, 4'h0);
        check("async_rst_errs", {ferr_w, perr_w, ovr_w}, 12'h000);
        for (int c = 0; c < 4; c++) check($sformatf("async_rst_data_ch%0d", c), rx_data_w[c], 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6 * BIT_CLKS) @(negedge clk);
        check("post_rst_idle", valid_w[0], 0);
        expect_ev(0, EV_DATA, 8'h5A);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1);
        check("post_rst_data", rx_data_w[0], 8'h5A);

        for (int c = 0; c < 4; c++) check($sformatf("sb_final_ch%0d", c), sb_q[c].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default `CLOCK_FREQ_p, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default `BAUD_RATE_p, line bit rate in baud.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, >= 8).
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-005 SHALL have parameter PARITY_EN, default 0; 1 = one parity bit follows data.
REQ-006 SHALL have parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-007 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-010 SHALL have port rx_data  output  DATA_BITS  last accepted frame data, LSB = first bit received.
REQ-011 SHALL have port rx_valid  output  1  rx_data holds an unconsumed frame.
REQ-012 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-014 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch.
REQ-015 SHALL have port overrun  output  1  one-cycle pulse: good frame dropped, rx_valid still high.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-017 SHALL generate a sample tick every DIV = floor(CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE)) clocks; DIV < 1 is an elaboration error.
REQ-018 SHALL hold the tick counter at zero in IDLE and restart it on the synchronized falling edge, aligning sampling to the start edge.
REQ-019 SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-020 SHALL decide each bit by 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 within the bit.
REQ-021 IDLE->START on falling edge; START->IDLE if start majority is 1 (glitch rejected, no output, no error), else START->DATA.
REQ-022 DATA SHALL shift DATA_BITS bits LSB first, then go to PARITY if PARITY_EN, else STOP.
REQ-023 PARITY SHALL compare the sampled bit to the computed parity; mismatch is recorded for the frame.
REQ-024 STOP majority 1 -> IDLE; majority 0 -> frame_err pulse, frame discarded, WAIT_IDLE until synchronized rx is 1.
REQ-025 Good stop with parity mismatch SHALL pulse parity_err and discard the frame.
REQ-026 Good frame SHALL load rx_data and set rx_valid on the clock after the stop-bit decision.
REQ-027 rx_valid SHALL stay high and rx_data stable until a cycle with rx_valid & rx_ready; rx_valid clears on the next edge.
REQ-028 Good frame completing while rx_valid is high and rx_ready is low SHALL pulse overrun and keep the old rx_data.
REQ-029 Good frame completing in the same cycle as a handshake SHALL load the new data, hold rx_valid high, and not pulse overrun.
REQ-030 At most one of frame_err, parity_err, overrun SHALL pulse per frame; frame_err has priority.

Reset
REQ-031 On rst_n low: state IDLE; counters 0; synchronizer flops 1; rx_data 0; rx_valid, frame_err, parity_err, overrun 0.
REQ-032 Reset mid-frame SHALL abandon the frame; the first falling edge after release starts a new frame.

Structure
REQ-033 Shared package uart_pkg SHALL hold the receiver state enum and the DIV computation function; CLOCK_FREQ_p and BAUD_RATE_p stay in UART_parameters.sv.
REQ-034 Tick generation SHALL be a sub-module uart_baud_tick (ports clk, rst_n, clear, tick), reusable by a transmitter.

Verification (CLOCK_FREQ=100_000_000, BAUD_RATE=115200, DIV=54, 8N1 unless noted)
REQ-035 Send 0xA5, rx_ready low -> rx_data=0xA5, rx_valid high until rx_ready pulse, then low next cycle; no error pulses.
REQ-036 Low glitch of 1/4 bit on idle line -> no rx_valid, no error pulse, state returns to IDLE.
REQ-037 Send 0x3C with stop bit 0, line held low 2 bit times -> one frame_err pulse, no rx_valid; a following 0x11 is received correctly.
REQ-038 Send 0x12 then 0x34 with rx_ready low -> one overrun pulse, rx_data stays 0x12; handshake landing on 0x34's completion cycle -> rx_data=0x34, no overrun.
REQ-039 PARITY_EN=1, even parity, send 0x01 with parity bit 0 -> one parity_err pulse, no rx_valid; parity bit 1 -> rx_data=0x01.
REQ-040 Assert rst_n during data bit 4 of 0xFF -> all outputs 0 asynchronously; after release, 0x5A is received correctly.
